// File: rtl/border_pkg.sv
// Shared types and constants for the play-field border collision checker.
// The power-up bounds below must match the border generator's reset values
// so that leaving reset never looks like a bound change.
package border_pkg;

  localparam int BORDER_COORD_W  = 4;

  localparam int BORDER_XMAX_DEF = 14;
  localparam int BORDER_XMIN_DEF = 0;
  localparam int BORDER_YMAX_DEF = 10;
  localparam int BORDER_YMIN_DEF = 0;

  typedef enum logic [2:0] {
    IDLE,
    HEAD_CHK,
    SCAN_RD,
    SCAN_CMP,
    DONE
  } border_chk_state_t;

endpackage

// File: rtl/border_cell_cmp.sv
// Point-versus-border collision test. The bound values are the wall cells
// themselves, so a cell sitting exactly on a bound counts as a hit.
module border_cell_cmp
  import border_pkg::*;
#(
  parameter int COORD_W = BORDER_COORD_W
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] xmax_i,
  input  logic [COORD_W-1:0] xmin_i,
  input  logic [COORD_W-1:0] ymax_i,
  input  logic [COORD_W-1:0] ymin_i,
  output logic               hit_o
);

  // A cell collides when it is on or beyond any of the four walls (unsigned compare).
  always_comb begin
    hit_o = (x_i <= xmin_i) || (x_i >= xmax_i) || (y_i <= ymin_i) || (y_i >= ymax_i);
  end

endmodule

// File: rtl/border_collision_checker.sv
// Border collision checker: flags head-versus-wall hits on every move and,
// whenever the bounds change, walks the body-segment RAM counting segments
// left on or outside the new wall.
// Build option: define BORDER_SCAN_GAMEOVER_EN to make a scan that finds any
// trapped segment also latch game_over.
module border_collision_checker
  import border_pkg::*;
#(
  parameter int MAX_LEN = 50,
  parameter int COORD_W = BORDER_COORD_W,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick_i,
  input  logic [COORD_W-1:0] head_x_i,
  input  logic [COORD_W-1:0] head_y_i,
  input  logic [COORD_W-1:0] xmax_i,
  input  logic [COORD_W-1:0] xmin_i,
  input  logic [COORD_W-1:0] ymax_i,
  input  logic [COORD_W-1:0] ymin_i,
  input  logic [IDX_W-1:0]   body_len_i,
  input  logic               game_clr_i,
  output logic [IDX_W-1:0]   seg_rd_addr_o,
  output logic               seg_rd_en_o,
  input  logic [COORD_W-1:0] seg_x_i,
  input  logic [COORD_W-1:0] seg_y_i,
  output logic               wall_hit_o,
  output logic               game_over_o,
  output logic               scan_busy_o,
  output logic               scan_done_o,
  output logic [IDX_W-1:0]   outside_cnt_o
);

  border_chk_state_t state_q, state_d;

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               game_over_q, game_over_d;
  logic               pend_scan_q, pend_scan_d;
  logic               pend_head_q, pend_head_d;
  logic [COORD_W-1:0] xmax_prev_q, xmin_prev_q, ymax_prev_q, ymin_prev_q;

  logic               bound_chg;
  logic               scan_take;
  logic               head_take;
  logic               head_hit;
  logic               seg_hit;
  logic               last_seg;

  border_cell_cmp #(.COORD_W(COORD_W)) u_head_cmp (
    .x_i    (head_x_i),
    .y_i    (head_y_i),
    .xmax_i (xmax_i),
    .xmin_i (xmin_i),
    .ymax_i (ymax_i),
    .ymin_i (ymin_i),
    .hit_o  (head_hit)
  );

  border_cell_cmp #(.COORD_W(COORD_W)) u_seg_cmp (
    .x_i    (seg_x_i),
    .y_i    (seg_y_i),
    .xmax_i (xmax_i),
    .xmin_i (xmin_i),
    .ymax_i (ymax_i),
    .ymin_i (ymin_i),
    .hit_o  (seg_hit)
  );

  assign bound_chg = (xmax_prev_q != xmax_i) || (xmin_prev_q != xmin_i) ||
                     (ymax_prev_q != ymax_i) || (ymin_prev_q != ymin_i);

  assign last_seg = (({1'b0, idx_q} + (IDX_W+1)'(1)) >= {1'b0, body_len_i});

  assign seg_rd_addr_o = idx_q;
  assign game_over_o   = game_over_q;
  assign outside_cnt_o = cnt_q;

  // Pending-work flags: a new request always wins over the consume of an older one.
  always_comb begin
    pend_scan_d = bound_chg   || (pend_scan_q && !scan_take);
    pend_head_d = move_tick_i || (pend_head_q && !head_take);
  end

  // Next-state and output decode; a pending bound change aborts any scan in flight.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = game_clr_i ? '0 : cnt_q;
    game_over_d = game_over_q && !game_clr_i;
    scan_take   = 1'b0;
    head_take   = 1'b0;
    wall_hit_o  = 1'b0;
    seg_rd_en_o = 1'b0;
    scan_busy_o = 1'b0;
    scan_done_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_scan_q) begin
          scan_take = 1'b1;
          idx_d     = IDX_W'(1);
          cnt_d     = '0;
          state_d   = SCAN_RD;
        end else if (pend_head_q) begin
          head_take = 1'b1;
          state_d   = HEAD_CHK;
        end
      end

      HEAD_CHK: begin
        wall_hit_o = head_hit;
        if (head_hit) begin
          game_over_d = 1'b1;
        end
        state_d = IDLE;
      end

      SCAN_RD: begin
        scan_busy_o = 1'b1;
        if (pend_scan_q) begin
          scan_take = 1'b1;
          idx_d     = IDX_W'(1);
          cnt_d     = '0;
        end else if (body_len_i <= IDX_W'(1)) begin
          state_d = DONE;
        end else begin
          seg_rd_en_o = 1'b1;
          state_d     = SCAN_CMP;
        end
      end

      SCAN_CMP: begin
        scan_busy_o = 1'b1;
        if (pend_scan_q) begin
          scan_take = 1'b1;
          idx_d     = IDX_W'(1);
          cnt_d     = '0;
          state_d   = SCAN_RD;
        end else begin
          if (seg_hit && (cnt_q < IDX_W'(MAX_LEN-1))) begin
            cnt_d = cnt_q + IDX_W'(1);
          end
          if (last_seg) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SCAN_RD;
          end
        end
      end

      DONE: begin
        scan_busy_o = 1'b1;
        scan_done_o = 1'b1;
`ifdef BORDER_SCAN_GAMEOVER_EN
        if (cnt_q != '0) begin
          game_over_d = 1'b1;
        end
`else
`endif
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scan bookkeeping and previous-bounds registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      game_over_q <= 1'b0;
      pend_scan_q <= 1'b0;
      pend_head_q <= 1'b0;
      xmax_prev_q <= COORD_W'(BORDER_XMAX_DEF);
      xmin_prev_q <= COORD_W'(BORDER_XMIN_DEF);
      ymax_prev_q <= COORD_W'(BORDER_YMAX_DEF);
      ymin_prev_q <= COORD_W'(BORDER_YMIN_DEF);
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      game_over_q <= game_over_d;
      pend_scan_q <= pend_scan_d;
      pend_head_q <= pend_head_d;
      xmax_prev_q <= xmax_i;
      xmin_prev_q <= xmin_i;
      ymax_prev_q <= ymax_i;
      ymin_prev_q <= ymin_i;
    end
  end

endmodule

// File: tb/tb_border_collision_checker.sv
// Directed bench for border_collision_checker: head checks, body scans,
// scan restart, merged move ticks, ordering and the short-body case.
// Expectations follow BORDER_SCAN_GAMEOVER_EN when it is defined.
module tb_border_collision_checker;

  localparam int COORD_W = 4;
  localparam int IDX_W   = 6;

`ifdef BORDER_SCAN_GAMEOVER_EN
  localparam logic SCAN_GO = 1'b1;
`else
  localparam logic SCAN_GO = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               move_tick;
  logic [COORD_W-1:0] head_x, head_y;
  logic [COORD_W-1:0] xmax, xmin, ymax, ymin;
  logic [IDX_W-1:0]   body_len;
  logic               game_clr;
  logic [IDX_W-1:0]   seg_rd_addr;
  logic               seg_rd_en;
  logic [COORD_W-1:0] seg_x, seg_y;
  logic               wall_hit, game_over, scan_busy, scan_done;
  logic [IDX_W-1:0]   outside_cnt;

  logic [COORD_W-1:0] memX [0:63];
  logic [COORD_W-1:0] memY [0:63];
  int                 readLog [$];

  int testsRun  = 0;
  int failCount = 0;
  int winCycle, doneCount, doneCycle, hitCount, hitCycle;

  border_collision_checker dut (
    .clk           (clk),
    .rst           (rst),
    .move_tick_i   (move_tick),
    .head_x_i      (head_x),
    .head_y_i      (head_y),
    .xmax_i        (xmax),
    .xmin_i        (xmin),
    .ymax_i        (ymax),
    .ymin_i        (ymin),
    .body_len_i    (body_len),
    .game_clr_i    (game_clr),
    .seg_rd_addr_o (seg_rd_addr),
    .seg_rd_en_o   (seg_rd_en),
    .seg_x_i       (seg_x),
    .seg_y_i       (seg_y),
    .wall_hit_o    (wall_hit),
    .game_over_o   (game_over),
    .scan_busy_o   (scan_busy),
    .scan_done_o   (scan_done),
    .outside_cnt_o (outside_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Body RAM model: data valid one cycle after the read strobe; every read address is logged.
  always @(posedge clk) begin
    if (seg_rd_en) begin
      seg_x <= memX[seg_rd_addr];
      seg_y <= memY[seg_rd_addr];
      readLog.push_back(int'(seg_rd_addr));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic startWindow();
    winCycle  = 0;
    doneCount = 0;
    doneCycle = -1;
    hitCount  = 0;
    hitCycle  = -1;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      winCycle++;
      if (scan_done === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = winCycle;
      end
      if (wall_hit === 1'b1) begin
        hitCount++;
        if (hitCycle < 0) hitCycle = winCycle;
      end
    end
  endtask

  task automatic setBounds(input int xa, input int xi, input int ya, input int yi);
    xmax = COORD_W'(xa);
    xmin = COORD_W'(xi);
    ymax = COORD_W'(ya);
    ymin = COORD_W'(yi);
  endtask

  task automatic pulseClear();
    game_clr = 1'b1;
    applyStimulus(1);
    game_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      memX[i] = '0;
      memY[i] = '0;
    end
    memX[1] = 4'd1; memY[1] = 4'd1;
    memX[2] = 4'd9; memY[2] = 4'd4;
    memX[3] = 4'd3; memY[3] = 4'd3;
    seg_x = '0;
    seg_y = '0;
    rst = 1'b1;
    move_tick = 1'b0;
    game_clr = 1'b0;
    head_x = 4'd5;
    head_y = 4'd5;
    body_len = 6'd1;
    setBounds(14, 0, 10, 0);

    // Reset values
    #2;
    checkOutput("rst_wall_hit", wall_hit, 0);
    checkOutput("rst_game_over", game_over, 0);
    checkOutput("rst_scan_busy", scan_busy, 0);
    checkOutput("rst_scan_done", scan_done, 0);
    checkOutput("rst_outside_cnt", outside_cnt, 0);
    checkOutput("rst_seg_rd_en", seg_rd_en, 0);
    checkOutput("rst_seg_rd_addr", seg_rd_addr, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // No spurious scan after reset
    startWindow();
    applyStimulus(4);
    checkOutput("post_rst_no_scan", doneCount, 0);
    checkOutput("post_rst_busy", scan_busy, 0);

    // Head (5,5) inside the field
    startWindow();
    move_tick = 1'b1;
    applyStimulus(1);
    move_tick = 1'b0;
    applyStimulus(3);
    checkOutput("inside_no_hit", hitCount, 0);
    checkOutput("inside_game_over", game_over, 0);

    // Head (14,3) on the right wall: wall_hit exactly 2 cycles after move_tick
    head_x = 4'd14;
    head_y = 4'd3;
    startWindow();
    move_tick = 1'b1;
    applyStimulus(1);
    move_tick = 1'b0;
    checkOutput("hit_c1", wall_hit, 0);
    applyStimulus(1);
    checkOutput("hit_c2", wall_hit, 1);
    game_clr = 1'b1;
    applyStimulus(1);
    game_clr = 1'b0;
    checkOutput("hit_c3_pulse_end", wall_hit, 0);
    checkOutput("set_beats_clr", game_over, 1);
    applyStimulus(2);
    checkOutput("game_over_sticky", game_over, 1);
    pulseClear();
    checkOutput("game_clr_clears", game_over, 0);
    head_x = 4'd5;
    head_y = 4'd5;

    // Full scan: 14/0/10/0 -> 8/0/4/0, body_len 4, only (9,4) is outside
    body_len = 6'd4;
    readLog.delete();
    startWindow();
    setBounds(8, 0, 4, 0);
    applyStimulus(2);
    checkOutput("scan_rd_en", seg_rd_en, 1);
    checkOutput("scan_rd_addr", seg_rd_addr, 1);
    checkOutput("scan_busy", scan_busy, 1);
    applyStimulus(5);
    checkOutput("scan_not_done_c7", doneCount, 0);
    applyStimulus(1);
    checkOutput("scan_done_c8", scan_done, 1);
    checkOutput("scan_cnt", outside_cnt, 1);
    applyStimulus(1);
    checkOutput("scan_done_pulse", scan_done, 0);
    checkOutput("scan_idle_busy", scan_busy, 0);
    checkOutput("scan_game_over", game_over, SCAN_GO);
    checkOutput("scan_reads", readLog.size(), 3);
    if (readLog.size() == 3) begin
      checkOutput("scan_addr1", readLog[0], 1);
      checkOutput("scan_addr2", readLog[1], 2);
      checkOutput("scan_addr3", readLog[2], 3);
    end
    pulseClear();
    checkOutput("clr_outside_cnt", outside_cnt, 0);
    checkOutput("clr_game_over", game_over, 0);

    // Restart: 10/2/10/0 counts (1,1); at idx=2 switch to 8/4/4/0 where all three are out
    readLog.delete();
    startWindow();
    setBounds(10, 2, 10, 0);
    applyStimulus(4);
    checkOutput("restart_partial_cnt", outside_cnt, 1);
    checkOutput("restart_addr_idx2", seg_rd_addr, 2);
    setBounds(8, 4, 4, 0);
    applyStimulus(10);
    checkOutput("restart_done_count", doneCount, 1);
    checkOutput("restart_done_cycle", doneCycle, 12);
    checkOutput("restart_cnt", outside_cnt, 3);
    checkOutput("restart_reads", readLog.size(), 5);
    if (readLog.size() == 5) begin
      checkOutput("restart_addr_first", readLog[2], 1);
      checkOutput("restart_addr_last", readLog[4], 3);
    end
    checkOutput("restart_game_over", game_over, SCAN_GO);
    pulseClear();

    // Two move ticks during a scan merge into one check against the latest head (0,5)
    startWindow();
    setBounds(14, 0, 10, 0);
    applyStimulus(3);
    move_tick = 1'b1;
    applyStimulus(1);
    move_tick = 1'b0;
    applyStimulus(1);
    head_x = 4'd0;
    head_y = 4'd5;
    move_tick = 1'b1;
    applyStimulus(1);
    move_tick = 1'b0;
    applyStimulus(8);
    checkOutput("merge_done_cycle", doneCycle, 8);
    checkOutput("merge_hit_count", hitCount, 1);
    checkOutput("merge_hit_cycle", hitCycle, 10);
    checkOutput("merge_cnt", outside_cnt, 0);
    checkOutput("merge_game_over", game_over, 1);
    pulseClear();

    // Simultaneous bound change and move_tick: scan first, then head check
    startWindow();
    setBounds(9, 0, 10, 0);
    move_tick = 1'b1;
    applyStimulus(1);
    move_tick = 1'b0;
    applyStimulus(11);
    checkOutput("simul_done_cycle", doneCycle, 8);
    checkOutput("simul_hit_cycle", hitCycle, 10);
    checkOutput("simul_hit_count", hitCount, 1);
    checkOutput("simul_cnt", outside_cnt, 1);

    // body_len=1: DONE 3 cycles after the change, no reads, count cleared
    body_len = 6'd1;
    readLog.delete();
    startWindow();
    setBounds(14, 0, 10, 0);
    applyStimulus(2);
    checkOutput("short_cnt_cleared", outside_cnt, 0);
    applyStimulus(2);
    checkOutput("short_done_cycle", doneCycle, 3);
    checkOutput("short_done_count", doneCount, 1);
    checkOutput("short_reads", readLog.size(), 0);
    checkOutput("short_cnt", outside_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/border_collision_checker.md
Name: border_collision_checker

Overview:
- Consumer side of the play-field border interface. Takes the live XMAX/XMIN/YMAX/YMIN bounds from the border generator together with the snake head position.
- Flags a wall hit on every head move.
- Whenever the bounds change, serially scans the snake body store and counts segments left on or outside the new wall.
- Sits between the border generator, the body-segment RAM and the game-state FSM.

Parameters:
- MAX_LEN, 50, body segment capacity (index 0 = head, 1..MAX_LEN-1 = body).
- COORD_W, 4, coordinate width.
- IDX_W, $clog2(MAX_LEN), segment index / count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- move_tick  in  1  one-cycle pulse: head moved this cycle.
- head_x, head_y  in  COORD_W  current head cell.
- xmax, xmin, ymax, ymin  in  COORD_W each  current border bounds.
- body_len  in  IDX_W  number of valid segments including head (1..MAX_LEN).
- game_clr  in  1  pulse: clear latched game_over and outside_cnt.
- seg_rd_addr  out  IDX_W  body RAM read address.
- seg_rd_en  out  1  body RAM read strobe.
- seg_x, seg_y  in  COORD_W  body RAM data, valid exactly 1 cycle after seg_rd_en.
- wall_hit  out  1  one-cycle pulse on a head collision.
- game_over  out  1  latched collision flag.
- scan_busy  out  1  body scan in progress.
- scan_done  out  1  one-cycle pulse at scan end.
- outside_cnt  out  IDX_W  segments found on/outside the wall by the last scan.

Behaviour:
- Wall rule: a cell (x,y) collides iff x<=xmin, x>=xmax, y<=ymin or y>=ymax. Bounds are the wall cells themselves. Comparisons are unsigned, COORD_W bits.
- Reset: wall_hit=0, game_over=0, scan_busy=0, scan_done=0, outside_cnt=0, seg_rd_en=0, seg_rd_addr=0, FSM=IDLE. Previous-bounds register loads defaults 14/0/10/0 so no spurious scan follows reset.
- Bound change: detected when any registered previous bound differs from the current input. The previous-bounds register updates every cycle.
- FSM states: IDLE, HEAD_CHK, SCAN_RD, SCAN_CMP, DONE.
- IDLE:
  - Pending scan (bound change) has priority, then pending head check.
  - Scan: go to SCAN_RD with idx=1 and outside_cnt cleared.
  - Head check: go to HEAD_CHK.
- HEAD_CHK (1 cycle): evaluate head against the current bounds. On collision, pulse wall_hit and set game_over. Return to IDLE.
  - Head-check latency: wall_hit is asserted 2 cycles after move_tick when IDLE.
- SCAN_RD: drive seg_rd_addr=idx and seg_rd_en=1, then go to SCAN_CMP.
- SCAN_CMP: compare seg_x/seg_y with the bounds; increment outside_cnt (saturating at MAX_LEN-1) on collision.
  - If idx+1 >= body_len, go to DONE; else idx++ and go to SCAN_RD.
  - Scan takes 2 cycles per segment.
- DONE: pulse scan_done for one cycle, then IDLE.
- scan_busy is high in SCAN_RD, SCAN_CMP and DONE.
- body_len<=1: the scan skips straight to DONE with outside_cnt=0.
- move_tick during a scan: sets a pending-head flag, serviced after DONE. Multiple ticks merge into one check against the latest head.
- Bound change during a scan: the scan restarts at idx=1, outside_cnt clears, and no scan_done is emitted for the aborted scan.
- Simultaneous move_tick and bound change in IDLE: the scan runs first, then the head check.
- game_clr: clears game_over and outside_cnt next cycle and does not affect FSM progress. If game_clr coincides with a set event, the set wins.
- game_over is sticky until game_clr or rst.

Optional Feature:
- Macro BORDER_SCAN_GAMEOVER_EN.
- Defined: in DONE, outside_cnt!=0 also sets game_over (a shrinking wall that traps the body ends the game).
- Undefined: a scan only updates outside_cnt, and game_over is driven solely by head collisions.

Decomposition:
- Package border_pkg holds:
  - the FSM state enum (border_chk_state_t);
  - default bound constants BORDER_XMAX_DEF=14, XMIN_DEF=0, YMAX_DEF=10, YMIN_DEF=0;
  - the COORD_W default.
- One natural sub-module, border_cell_cmp: a combinational point-vs-bounds collision test, instantiated twice (head and scanned segment).

Test Plan:
- Reset, bounds 14/0/10/0, head (5,5), move_tick -> no wall_hit; game_over=0.
- Head (14,3), move_tick in IDLE -> wall_hit pulse exactly 2 cycles later; game_over=1 until game_clr, then 0.
- body_len=4, segments (1,1),(9,4),(3,3); bounds change 14/0/10/0 -> 8/0/4/0 -> seg reads addr 1,2,3; outside_cnt=1; scan_done 8 cycles after the change (7 cycles from IDLE entry: 1 detect + 3x2 scan + DONE); game_over=1 only with BORDER_SCAN_GAMEOVER_EN.
- Bound change mid-scan at idx=2 -> scan restarts at addr 1; a single scan_done; outside_cnt reflects the new bounds only.
- move_tick twice during a scan, head (0,5) -> exactly one wall_hit after scan_done.
- Simultaneous bound change and move_tick -> scan_done precedes wall_hit; body_len=1 -> scan_done 3 cycles after change with outside_cnt=0.
